// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state encodings (also visible on the STATE debug output),
// the instruction class constants decoded from Op, and the datapath mux
// select constants driven onto ALUSrcA/ALUSrcB/ResultSrc/AdrSrc.
package multicycle_controller_pkg;

    typedef logic [1:0] sel_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instruction classes carried on Op
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_UNDEF  = 2'b11;

    // ALU operand A select
    localparam sel_t SRCA_REG   = 2'b00;
    localparam sel_t SRCA_PC    = 2'b01;
    // ALU operand B select
    localparam sel_t SRCB_REG   = 2'b00;
    localparam sel_t SRCB_IMM   = 2'b01;
    localparam sel_t SRCB_FOUR  = 2'b10;
    // Result bus select
    localparam sel_t RES_ALUOUT = 2'b00;
    localparam sel_t RES_RDATA  = 2'b01;
    localparam sel_t RES_ALU    = 2'b10;
    // Memory address select
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALU    = 1'b1;

    // States that wait on MEM_READY and are guarded by the timeout timer
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the instruction decoder/datapath and the controller.
// Inputs to the controller: Op, FUNCT, COND_EX, NO_WRITE, MEM_READY.
// Outputs from the controller: IRWrite, NextPC, RegW, MemW, Branch, ALU_Op,
// AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, MEM_ERR, STATE.
// modport slave is the controller side, modport master the datapath side.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [1:0] Op;
    logic [5:0] FUNCT;
    logic       COND_EX;
    logic       NO_WRITE;
    logic       MEM_READY;

    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALU_Op;
    logic       AdrSrc;
    sel_t       ALUSrcA;
    sel_t       ALUSrcB;
    sel_t       ResultSrc;
    logic       MEM_ERR;
    logic [3:0] STATE;

    modport master (
        output Op, FUNCT, COND_EX, NO_WRITE, MEM_READY,
        input  IRWrite, NextPC, RegW, MemW, Branch, ALU_Op, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, MEM_ERR, STATE
    );

    modport slave (
        input  Op, FUNCT, COND_EX, NO_WRITE, MEM_READY,
        output IRWrite, NextPC, RegW, MemW, Branch, ALU_Op, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, MEM_ERR, STATE
    );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory-waiting state spends with
// MEM_READY low and flags a timeout when the limit is reached.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, clears the count
//   active_i   controller is in a memory-waiting state
//   ready_i    memory completes the access this cycle
//   restart_i  next cycle is a fresh entry into a state; clear the count
//   timeout_o  count at limit while still not ready (combinational)
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic ready_i,
    input  logic restart_i,
    output logic timeout_o
);
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          at_limit;

    assign at_limit  = (count_q == CW'(WAIT_LIMIT));
    // Ready in the limit cycle is a success, so timeout needs ready low
    assign timeout_o = active_i && !ready_i && at_limit;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (active_i && !ready_i && !at_limit) begin
            // Saturating: the limit cycle always exits the state, never wraps
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle datapath through
// fetch, decode, memory, ALU and branch steps, with a memory wait timeout.
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous active-high reset; outputs forced to idle FETCH values
//   bus    controller side of multicycle_controller_if (instruction class,
//          condition/memory status in; datapath strobes, mux selects,
//          MEM_ERR pulse and STATE debug out)
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                   CLK,
    input  logic                   RESET,
    multicycle_controller_if.slave bus
);
    state_t state_q, state_d;
    logic   timeout;
    logic   restart;
    logic   ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src, mem_err;
    sel_t   alu_src_a, alu_src_b, result_src;

    // Only the I and L flags of FUNCT steer the sequence
    logic unused_funct_bits;
    assign unused_funct_bits = ^bus.FUNCT[4:1];

    // Any state change is a fresh entry; a timeout in FETCH re-enters FETCH
    assign restart = (state_d != state_q) || timeout;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_mem_wait_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .active_i  (is_wait_state(state_q)),
        .ready_i   (bus.MEM_READY),
        .restart_i (restart),
        .timeout_o (timeout)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.MEM_READY) state_d = S_DECODE;
            S_DECODE: begin
                if (!bus.COND_EX || bus.Op == OP_UNDEF) begin
                    state_d = S_FETCH;
                end else if (bus.Op == OP_MEM) begin
                    state_d = S_MEMADR;
                end else if (bus.Op == OP_BRANCH) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = bus.FUNCT[5] ? S_EXECI : S_EXECR;
                end
            end
            S_MEMADR: state_d = bus.FUNCT[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.MEM_READY)  state_d = S_MEMWB;
                else if (timeout)   state_d = S_FETCH;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.MEM_READY || timeout) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        mem_err    = timeout;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = bus.MEM_READY;
                next_pc    = bus.MEM_READY;
            end
            S_DECODE: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_MEMADR: alu_src_b = SRCB_IMM;
            S_MEMRD:  adr_src   = ADR_ALU;
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src = ADR_ALU;
                mem_w   = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            S_ALUWB: begin
                alu_op = 1'b1;
                reg_w  = !bus.NO_WRITE;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
            default: ;
        endcase
        // Reset is synchronous, so the state register may still hold an
        // old state while RESET is high; mask to idle FETCH values
        if (RESET) begin
            ir_write   = 1'b0;
            next_pc    = 1'b0;
            reg_w      = 1'b0;
            mem_w      = 1'b0;
            branch     = 1'b0;
            alu_op     = 1'b0;
            mem_err    = 1'b0;
            adr_src    = ADR_PC;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
        end
    end

    assign bus.IRWrite   = ir_write;
    assign bus.NextPC    = next_pc;
    assign bus.RegW      = reg_w;
    assign bus.MemW      = mem_w;
    assign bus.Branch    = branch;
    assign bus.ALU_Op    = alu_op;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.MEM_ERR   = mem_err;
    assign bus.STATE     = RESET ? 4'(S_FETCH) : 4'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instruction sequences with
// literal expectations, then randomized instructions, memory stalls and
// resets, all checked each cycle against an instruction-level model.
module tb_multicycle_controller;
    localparam int LIMIT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(
        .WAIT_LIMIT (LIMIT)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Per-state output tables indexed by state number
    // FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXECR EXECI ALUWB BRANCH
    int tab_a[10]   = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int tab_b[10]   = '{2, 2, 1, 0, 0, 0, 0, 1, 0, 1};
    int tab_res[10] = '{2, 2, 0, 0, 1, 0, 0, 0, 0, 2};
    int tab_adr[10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    int tab_alu[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

    // Model: current step, cycles waited, remaining steps of the instruction
    int m_state = 0;
    int m_wait  = 0;
    int m_plan[$];

    // Values sampled from the DUT in the most recent cycle
    int s_state, s_out, s_regw, s_memw, s_branch, s_aluop, s_err, s_irw;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int expect_out(int st, logic r, logic rdy, logic nw, int wt);
        int   s    = r ? 0 : st;
        logic live = !r;
        logic irw  = live && s == 0 && rdy;
        logic regw = live && (s == 4 || (s == 8 && !nw));
        logic memw = live && s == 5;
        logic br   = live && s == 9;
        logic err  = live && (s == 0 || s == 3 || s == 5) && !rdy && wt == LIMIT;
        logic [13:0] v;
        v = {irw, irw, regw, memw, br, 1'(tab_alu[s]), 1'(tab_adr[s]),
             2'(tab_a[s]), 2'(tab_b[s]), 2'(tab_res[s]), err};
        return int'(v);
    endfunction

    task automatic enter(input int s);
        m_state = s;
        m_wait  = 0;
    endtask

    task automatic advance();
        if (m_plan.size() > 0) enter(m_plan.pop_front());
        else                   enter(0);
    endtask

    task automatic model_step(input logic r, input logic [1:0] op, input logic [5:0] fn,
                              input logic ce, input logic rdy);
        if (r) begin
            m_plan.delete();
            enter(0);
        end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (rdy) begin
                if (m_state == 0) enter(1);
                else              advance();
            end else if (m_wait == LIMIT) begin
                m_plan.delete();
                enter(0);
            end else begin
                m_wait++;
            end
        end else if (m_state == 1) begin
            m_plan.delete();
            if (ce && op != 2'b11) begin
                case (op)
                    2'b01:   if (fn[0]) m_plan = '{2, 3, 4}; else m_plan = '{2, 5};
                    2'b10:   m_plan = '{9};
                    default: m_plan = '{fn[5] ? 7 : 6, 8};
                endcase
            end
            advance();
        end else begin
            advance();
        end
    endtask

    // One clock: drive, sample away from the edge, compare, step the model
    task automatic cycle(input logic r, input logic [1:0] op, input logic [5:0] fn,
                         input logic ce, input logic nw, input logic rdy);
        logic [13:0] v;
        @(negedge clk);
        rst           = r;
        bus.Op        = op;
        bus.FUNCT     = fn;
        bus.COND_EX   = ce;
        bus.NO_WRITE  = nw;
        bus.MEM_READY = rdy;
        #1;
        v = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALU_Op,
             bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.MEM_ERR};
        s_out    = int'(v);
        s_state  = int'(bus.STATE);
        s_regw   = int'(bus.RegW);
        s_memw   = int'(bus.MemW);
        s_branch = int'(bus.Branch);
        s_aluop  = int'(bus.ALU_Op);
        s_err    = int'(bus.MEM_ERR);
        s_irw    = int'(bus.IRWrite);
        chk("model_state", s_state, r ? 0 : m_state);
        chk("model_outputs", s_out, expect_out(m_state, r, rdy, nw, m_wait));
        model_step(r, op, fn, ce, rdy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 2'b00, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    int st_dp[4]   = '{0, 1, 6, 8};
    int st_cmp[5]  = '{0, 1, 6, 8, 0};
    int st_ld[9]   = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    int rdy_ld[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    int st_br[4]   = '{0, 1, 9, 0};
    int st_sw39[5] = '{0, 1, 2, 5, 5};

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        logic       ce;
        logic       rdy;
        int         mode;
        int         memw_cnt;

        // Reset state
        do_reset();
        do_reset();
        chk("reset_state", s_state, 0);
        chk("reset_outputs", s_out, 14'b00_0000_0_01_10_10_0);

        // Data-processing register op
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b00, 6'b001001, 1'b1, 1'b0, 1'b1);
            chk("dp_state", s_state, st_dp[i]);
            chk("dp_regw", s_regw, int'(i == 3));
            chk("dp_aluop", s_aluop, int'(i >= 2));
        end

        // Compare-style op: write-back suppressed
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b00, 6'b010101, 1'b1, 1'b1, 1'(i == 0));
            chk("cmp_state", s_state, st_cmp[i]);
            chk("cmp_regw", s_regw, 0);
        end

        // Load with three stall cycles in MEMRD
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 2'b01, 6'b000001, 1'b1, 1'b0, 1'(rdy_ld[i]));
            chk("load_state", s_state, st_ld[i]);
            chk("load_regw", s_regw, int'(i == 7));
        end

        // Store with memory never ready: 16 MemW cycles, then timeout
        do_reset();
        memw_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'b01, 6'b000000, 1'b1, 1'b0, 1'(i == 0));
            memw_cnt += s_memw;
            chk("store_err", s_err, int'(i == 18));
            if (i == 19) chk("store_after_timeout_state", s_state, 0);
        end
        chk("store_memw_cycles", memw_cnt, 16);

        // Condition failed: straight back to FETCH
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b00, 6'b000000, 1'b0, 1'b0, 1'(i == 0));
            chk("nocond_state", s_state, (i == 1) ? 1 : 0);
            chk("nocond_strobes", s_regw | s_memw | s_branch, 0);
        end

        // Branch
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b10, 6'b000000, 1'b1, 1'b0, 1'(i == 0));
            chk("branch_state", s_state, st_br[i]);
            chk("branch_strobe", s_branch, int'(i == 2));
        end

        // Reset in the middle of MEMWR, then counter must start from zero
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b01, 6'b000000, 1'b1, 1'b0, 1'(i == 0));
            chk("rstwr_state", s_state, st_sw39[i]);
        end
        chk("rstwr_memw_before", s_memw, 1);
        cycle(1'b1, 2'b01, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("rstwr_state_in_reset", s_state, 0);
        chk("rstwr_memw_in_reset", s_memw, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 2'b01, 6'b000000, 1'b1, 1'b0, 1'b0);
            chk("rstwr_fetch_state", s_state, 0);
            chk("rstwr_fetch_err", s_err, int'(i == 15));
            chk("rstwr_fetch_irw", s_irw, 0);
        end

        // Ready arriving in the limit cycle is a success; undefined op
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 2'b11, 6'b000000, 1'b1, 1'b0, 1'(i == 15));
            chk("edge_err", s_err, 0);
            chk("edge_irw", s_irw, int'(i == 15));
        end
        cycle(1'b0, 2'b11, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("undef_decode_state", s_state, 1);
        cycle(1'b0, 2'b11, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("undef_back_to_fetch", s_state, 0);

        // Randomized instructions, stalls and resets against the model
        op   = 2'b00;
        fn   = 6'd0;
        ce   = 1'b1;
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_state == 0) begin
                op = 2'($urandom_range(0, 3));
                fn = 6'($urandom);
                ce = ($urandom_range(0, 7) != 0);
                if (m_wait == 0) mode = $urandom_range(0, 3);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = 1'b0;
                default: rdy = ($urandom_range(0, 9) != 0);
            endcase
            cycle(1'($urandom_range(0, 99) == 0), op, fn, ce,
                  1'($urandom_range(0, 1)), rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, maximum memory wait cycles tolerated per memory state before timeout.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 FUNCT  input  6  instruction bits [25:20]: bit5 = immediate flag I, bit0 = load flag L for memory ops.
REQ-006 COND_EX  input  1  condition check passed for the current instruction; sampled in DECODE.
REQ-007 NO_WRITE  input  1  from the ALU decoder; suppresses register write-back (CMP).
REQ-008 MEM_READY  input  1  memory completes the current access this cycle.
REQ-009 IRWrite, NextPC, RegW, MemW, Branch, ALU_Op  output  1 each  instruction-register load, PC update, register write, memory write, branch request, data-processing ALU decode enable.
REQ-010 AdrSrc  output  1  0 = PC address, 1 = ALU result address.
REQ-011 ALUSrcA  output  2  and ALUSrcB  output  2; ResultSrc  output  2  datapath mux selects.
REQ-012 MEM_ERR  output  1  one-cycle pulse on memory timeout.
REQ-013 STATE  output  4  current state encoding, for debug.

Function
REQ-014 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; all outputs decode from the current state plus MEM_READY/NO_WRITE gating only.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MEM_READY; -> DECODE when MEM_READY=1, else hold.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; COND_EX=0 or Op=11 -> FETCH; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00 -> EXECI if FUNCT[5]=1 else EXECR.
REQ-017 MEMADR: ALUSrcA=00, ALUSrcB=01, ALU_Op=0; -> MEMRD if FUNCT[0]=1 else MEMWR.
REQ-018 MEMRD: AdrSrc=1, ResultSrc=00; -> MEMWB when MEM_READY=1, else hold.
REQ-019 MEMWB: ResultSrc=01, RegW=1 for exactly one cycle; -> FETCH.
REQ-020 MEMWR: AdrSrc=1, MemW=1 held every cycle in state; -> FETCH when MEM_READY=1.
REQ-021 EXECR: ALUSrcA=00, ALUSrcB=00, ALU_Op=1; EXECI: ALUSrcA=00, ALUSrcB=01, ALU_Op=1; both -> ALUWB.
REQ-022 ALUWB: ResultSrc=00, ALU_Op=1, RegW = NOT NO_WRITE; -> FETCH.
REQ-023 BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1; -> FETCH.
REQ-024 Outputs not listed for a state SHALL be 0.
REQ-025 Latency (MEM_READY=1 throughout): data-processing 4 cycles, load 5, store 4, branch 3, condition-failed/undefined 2.
REQ-026 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle MEM_READY=0 in those states.
REQ-027 When the counter equals WAIT_LIMIT with MEM_READY still 0, MEM_ERR SHALL pulse one cycle and the FSM SHALL go to FETCH with no RegW/MemW/IRWrite issued for that access.
REQ-028 MEM_READY=1 in the same cycle the counter reaches WAIT_LIMIT SHALL count as success; no MEM_ERR.
REQ-029 Counter width SHALL be $clog2(WAIT_LIMIT+1) and SHALL never wrap.

Reset
REQ-030 RESET=1 at a rising edge SHALL force state FETCH and counter 0, aborting any state mid-instruction.
REQ-031 While RESET=1, IRWrite, NextPC, RegW, MemW, Branch, MEM_ERR SHALL be 0; selects take FETCH values; STATE=FETCH encoding 4'd0.

Structure
REQ-032 State encodings (FETCH=0 ... BRANCH=9), Op class constants and mux-select constants SHALL live in a shared package.
REQ-033 The wait counter with timeout compare SHALL be one sub-module, mem_wait_timer.

Verification
REQ-034 Reset then Op=00, FUNCT=6'b001001, COND_EX=1, MEM_READY=1 -> FETCH,DECODE,EXECR,ALUWB; RegW=1 in ALUWB only; ALU_Op=1 in EXECR/ALUWB.
REQ-035 Op=00, FUNCT=6'b010101, NO_WRITE=1 -> EXECR then ALUWB with RegW=0, back to FETCH.
REQ-036 Load Op=01, FUNCT[0]=1, MEM_READY low 3 cycles in MEMRD -> MEMRD held 4 cycles, RegW pulses once in MEMWB.
REQ-037 Store, MEM_READY held 0, WAIT_LIMIT=15 -> MemW=1 for 16 cycles, MEM_ERR pulse, next state FETCH.
REQ-038 COND_EX=0 in DECODE -> FETCH next cycle, no RegW/MemW/Branch asserted.
REQ-039 RESET asserted in MEMWR with MemW=1 -> next cycle STATE=0, MemW=0, counter 0.
